// File: rtl/hazard_tracker.sv
// Producer side of the decode load-use interlock: tracks rd/load of X, M, W and
// drives lw/rdprev/flush, the pipeline write enables and the multdiv hold.
module hazard_tracker #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MD_TIMEOUT   = 40
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       stall,
    input  logic       d_wen,
    input  logic [4:0] d_rd,
    input  logic       d_is_lw,
    input  logic       x_redirect,
    input  logic       x_md_start,
    input  logic       md_ready,
    output logic       lw,
    output logic [4:0] rdprev,
    output logic       flush,
    output logic       pc_we,
    output logic       fd_we,
    output logic       dx_we,
    output logic       xm_we,
    output logic       md_error,
    output logic [4:0] m_rd,
    output logic [4:0] w_rd,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MD_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] MD_LAST      = 8'(MD_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       md_error_nxt;

    // Only rd and the load flag of X are consumed downstream; M and W keep rd only.
    logic       x_valid, x_lw, m_valid, w_valid;
    logic [4:0] x_rd, m_rd_q, w_rd_q;
    logic       x_in_valid;

    // md_ready is a level qualifier sampled only in MD_WAIT: it ends the hold in
    // the cycle it is seen, with every write enable raised that same cycle.
    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        cnt_nxt      = cnt;
        md_error_nxt = md_error;
        flush        = 1'b0;
        pc_we        = 1'b1;
        fd_we        = 1'b1;
        dx_we        = 1'b1;
        xm_we        = 1'b1;
        case (state)
            RUN: begin
                if (x_md_start) begin
                    state_nxt = MD_WAIT;
                    cnt_nxt   = 8'd0;
                    pc_we     = ~stall;
                    fd_we     = ~stall;
                end else if (x_redirect) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = FLUSH_RELOAD;
                    end
                end else if (stall) begin
                    pc_we = 1'b0;
                    fd_we = 1'b0;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (x_redirect) begin
                    fcnt_nxt = FLUSH_RELOAD;
                end else if (fcnt == 3'd1) begin
                    state_nxt = RUN;
                end else begin
                    fcnt_nxt = fcnt - 3'd1;
                end
            end
            MD_WAIT: begin
                if (md_ready) begin
                    state_nxt = RUN;
                end else begin
                    pc_we = 1'b0;
                    fd_we = 1'b0;
                    dx_we = 1'b0;
                    xm_we = 1'b0;
                    if (cnt != 8'hff) begin
                        cnt_nxt = cnt + 8'd1;
                    end
                    if (cnt == MD_LAST) begin
                        md_error_nxt = 1'b1;
                        state_nxt    = RUN;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // r0 is never a hazard source, so it is never marked valid.
    assign x_in_valid = d_wen & ~stall & ~flush & (d_rd != 5'd0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= RUN;
            fcnt     <= 3'd0;
            cnt      <= 8'd0;
            md_error <= 1'b0;
            x_valid  <= 1'b0;
            x_rd     <= 5'd0;
            x_lw     <= 1'b0;
            m_valid  <= 1'b0;
            m_rd_q   <= 5'd0;
            w_valid  <= 1'b0;
            w_rd_q   <= 5'd0;
        end else begin
            state    <= state_nxt;
            fcnt     <= fcnt_nxt;
            cnt      <= cnt_nxt;
            md_error <= md_error_nxt;
            if (xm_we) begin
                w_valid <= m_valid;
                w_rd_q  <= m_rd_q;
                m_valid <= x_valid;
                m_rd_q  <= x_rd;
            end
            if (dx_we) begin
                x_valid <= x_in_valid;
                x_rd    <= d_rd;
                x_lw    <= d_is_lw;
            end
        end
    end

    assign lw        = x_valid & x_lw;
    assign rdprev    = x_valid ? x_rd : 5'd0;
    assign m_rd      = m_valid ? m_rd_q : 5'd0;
    assign w_rd      = w_valid ? w_rd_q : 5'd0;
    assign fsm_state = state;

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed scenarios plus random traffic
// compared each cycle against a cycle-count/queue model of the interlock rules.
module tb_hazard_tracker;

    localparam int FC  = 2;
    localparam int MDT = 40;

    logic       clock, resetn;
    logic       stall, d_wen, d_is_lw, x_redirect, x_md_start, md_ready;
    logic [4:0] d_rd;
    logic       lw, flush, pc_we, fd_we, dx_we, xm_we, md_error;
    logic [4:0] rdprev, m_rd, w_rd;
    logic [1:0] fsm_state;

    hazard_tracker #(.FLUSH_CYCLES(FC), .MD_TIMEOUT(MDT)) dut (
        .clock(clock), .resetn(resetn), .stall(stall), .d_wen(d_wen), .d_rd(d_rd),
        .d_is_lw(d_is_lw), .x_redirect(x_redirect), .x_md_start(x_md_start),
        .md_ready(md_ready), .lw(lw), .rdprev(rdprev), .flush(flush), .pc_we(pc_we),
        .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .md_error(md_error),
        .m_rd(m_rd), .w_rd(w_rd), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // model: pipe_q holds {lw, rd} for X, M, W (entry 0 = X); an empty slot is 0
    logic [5:0] pipe_q[$];
    int         cyc = 0;
    int         flush_end = 0;
    int         md_begin = 0;
    bit         in_md = 1'b0;
    bit         exp_err = 1'b0;

    logic       obs_flush;
    logic [3:0] obs_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pipe_q.delete();
        repeat (3) pipe_q.push_back(6'd0);
        flush_end = cyc;
        in_md     = 1'b0;
        exp_err   = 1'b0;
    endtask

    // driver + scoreboard: called just after a rising edge, returns just after the next
    task automatic step(input logic st, input logic wen, input logic [4:0] rd, input logic islw,
                        input logic redir, input logic mdst, input logic mdrdy);
        bit         fl_act;
        bit         e_flush;
        logic [3:0] e_we;
        logic [5:0] new_ent;
        stall = st; d_wen = wen; d_rd = rd; d_is_lw = islw;
        x_redirect = redir; x_md_start = mdst; md_ready = mdrdy;
        #4;
        fl_act = (cyc < flush_end);
        if (in_md) begin
            e_flush = 1'b0;
            e_we    = mdrdy ? 4'hf : 4'h0;
        end else if (fl_act) begin
            e_flush = 1'b1;
            e_we    = 4'hf;
        end else if (!mdst && redir) begin
            e_flush = 1'b1;
            e_we    = 4'hf;
        end else begin
            e_flush = 1'b0;
            e_we    = st ? 4'b0011 : 4'hf;
        end
        obs_flush = flush;
        obs_we    = {pc_we, fd_we, dx_we, xm_we};
        check("flush", 32'(flush), 32'(e_flush));
        check("we", 32'(obs_we), 32'(e_we));
        check("lw", 32'(lw), 32'(pipe_q[0][5]));
        check("rdprev", 32'(rdprev), 32'(pipe_q[0][4:0]));
        check("m_rd", 32'(m_rd), 32'(pipe_q[1][4:0]));
        check("w_rd", 32'(w_rd), 32'(pipe_q[2][4:0]));
        check("md_error", 32'(md_error), 32'(exp_err));
        new_ent = (wen && !st && !e_flush && rd != 5'd0) ? {islw, rd} : 6'd0;
        if (!(in_md && !mdrdy)) begin
            pipe_q.push_front(new_ent);
            pipe_q.delete(3);
        end
        if (in_md) begin
            if (mdrdy) in_md = 1'b0;
            else if (cyc - md_begin == MDT - 1) begin
                in_md   = 1'b0;
                exp_err = 1'b1;
            end
        end else if (fl_act) begin
            if (redir) flush_end = cyc + FC;
        end else if (mdst) begin
            in_md    = 1'b1;
            md_begin = cyc + 1;
        end else if (redir) begin
            flush_end = cyc + FC;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    // asserts reset mid-cycle and checks outputs fall to reset values with no edge
    task automatic async_reset_check(input string tag, input logic pre_flush, input logic pre_pc_we);
        stall = 1'b0; d_wen = 1'b1; d_rd = 5'd17; d_is_lw = 1'b1;
        x_redirect = 1'b0; x_md_start = 1'b0; md_ready = 1'b0;
        #1;
        check({tag, "_pre_flush"}, 32'(flush), 32'(pre_flush));
        check({tag, "_pre_pc_we"}, 32'(pc_we), 32'(pre_pc_we));
        #1 resetn = 1'b0;
        #1;
        check({tag, "_flush"}, 32'(flush), 32'd0);
        check({tag, "_we"}, 32'({pc_we, fd_we, dx_we, xm_we}), 32'hf);
        check({tag, "_slots"}, 32'({lw, rdprev, m_rd, w_rd}), 32'd0);
        check({tag, "_md_error"}, 32'(md_error), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'd0);
        model_reset();
        @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    initial begin
        int s;
        int z;
        resetn = 1'b0;
        stall = 1'b0; d_wen = 1'b1; d_rd = 5'd5; d_is_lw = 1'b1;
        x_redirect = 1'b0; x_md_start = 1'b0; md_ready = 1'b0;
        model_reset();
        #2;
        check("rst_we", 32'({pc_we, fd_we, dx_we, xm_we}), 32'hf);
        check("rst_flush", 32'(flush), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_slots", 32'({lw, rdprev, m_rd, w_rd}), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_md_error", 32'(md_error), 32'd0);
        resetn = 1'b1;

        // load-use
        step(0, 1, 5'd7, 1, 0, 0, 0);
        check("lu_lw", 32'(lw), 32'd1);
        check("lu_rdprev", 32'(rdprev), 32'd7);
        step(1, 1, 5'd3, 0, 0, 0, 0);
        check("lu_stall_we", 32'(obs_we), 32'b0011);
        check("lu_bubble", 32'({lw, rdprev}), 32'd0);
        check("lu_m_rd", 32'(m_rd), 32'd7);

        // load to r0
        step(0, 1, 5'd0, 1, 0, 0, 0);
        check("r0_x", 32'({lw, rdprev}), 32'd0);
        check("r0_w_rd", 32'(w_rd), 32'd7);

        // single redirect
        s = 0;
        step(0, 1, 5'd9, 0, 1, 0, 0); s += int'(obs_flush);
        step(0, 1, 5'd9, 0, 0, 0, 0); s += int'(obs_flush);
        check("redir_bubble", 32'(rdprev), 32'd0);
        step(0, 1, 5'd9, 0, 0, 0, 0); s += int'(obs_flush);
        check("redir_after", 32'(rdprev), 32'd9);
        step(0, 1, 5'd9, 0, 0, 0, 0); s += int'(obs_flush);
        check("redir_len", 32'(s), 32'd2);

        // back-to-back redirect extends the window
        s = 0;
        step(0, 1, 5'd10, 0, 1, 0, 0); s += int'(obs_flush);
        step(1, 1, 5'd10, 0, 1, 0, 0); s += int'(obs_flush);
        check("redir2_stall_ignored", 32'(obs_we), 32'hf);
        step(0, 1, 5'd10, 0, 0, 0, 0); s += int'(obs_flush);
        check("redir2_bubble", 32'({lw, rdprev, m_rd}), 32'd0);
        step(0, 1, 5'd10, 0, 0, 0, 0); s += int'(obs_flush);
        step(0, 1, 5'd10, 0, 0, 0, 0); s += int'(obs_flush);
        check("redir2_len", 32'(s), 32'd3);

        // multdiv hold, ready after 10 cycles
        step(0, 1, 5'd11, 0, 0, 0, 0);
        step(0, 1, 5'd12, 0, 0, 0, 0);
        step(0, 1, 5'd13, 1, 0, 1, 0);
        z = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 5'(20 + i), 1, (i == 3), 0, 0);
            z += int'(obs_we == 4'h0);
        end
        check("md_hold_cycles", 32'(z), 32'd10);
        check("md_frozen", 32'({lw, rdprev, m_rd, w_rd}), {17'd0, 1'b1, 5'd13, 5'd12, 5'd11});
        step(0, 1, 5'd14, 0, 0, 0, 1);
        check("md_ready_we", 32'(obs_we), 32'hf);
        check("md_release", 32'({rdprev, m_rd, w_rd}), {17'd0, 5'd14, 5'd13, 5'd12});

        // multdiv timeout
        step(0, 1, 5'd15, 0, 0, 1, 0);
        z = 0;
        for (int i = 0; i < MDT; i++) begin
            if (i == MDT - 1) check("md_err_not_early", 32'(md_error), 32'd0);
            step(0, 1, 5'd16, 0, 0, 0, 0);
            z += int'(obs_we == 4'h0);
        end
        check("md_timeout_cycles", 32'(z), 32'(MDT));
        check("md_err_set", 32'(md_error), 32'd1);
        step(0, 1, 5'd16, 0, 0, 0, 1);
        check("md_after_timeout_we", 32'(obs_we), 32'hf);
        for (int i = 0; i < 5; i++) step(0, 0, 5'd0, 0, 0, 0, 1);
        check("md_err_sticky", 32'(md_error), 32'd1);

        // async reset mid-FLUSH and mid-MD_WAIT
        step(0, 1, 5'd18, 0, 0, 0, 0);
        step(0, 1, 5'd19, 0, 1, 0, 0);
        async_reset_check("rst_flush", 1'b1, 1'b1);
        step(0, 1, 5'd21, 1, 0, 0, 0);
        check("rst_flush_run", 32'({lw, rdprev}), {26'd0, 1'b1, 5'd21});
        step(0, 1, 5'd22, 0, 0, 1, 0);
        step(0, 1, 5'd23, 0, 0, 0, 0);
        async_reset_check("rst_md", 1'b0, 1'b0);
        step(0, 1, 5'd24, 0, 0, 0, 0);
        check("rst_md_run_we", 32'(obs_we), 32'hf);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 1), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
